// File: rtl/mips_single_cycle.sv
// Single-cycle MIPS-subset CPU. PC, register file, instruction ROM and data RAM all live here.
// One instruction is fetched, executed and written back on every rising clk edge.

module pc (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_next,
  output logic [31:0] pc_out
);
  always_ff @(posedge clk) begin
    if (reset) pc_out <= '0;
    else       pc_out <= pc_next;
  end
endmodule

module register_file (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] regs [0:31];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  // $0 is forced on the read side as well, so it is zero even before the first reset
  assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];
endmodule

module instruction_memory #(
  parameter int    IMEM_WORDS = 64,
  parameter string IMEM_INIT  = ""
) (
  input  logic [31:0] addr,
  output logic [31:0] instr
);
  localparam int AW = $clog2(IMEM_WORDS);

  logic [31:0] rom [0:IMEM_WORDS-1];
  logic        unused_addr;

  initial begin
    for (int i = 0; i < IMEM_WORDS; i++) rom[i] = '0;
    if (IMEM_INIT == "") begin
      rom[0] = 32'h20010003;  // addi $1,$0,3
      rom[1] = 32'h20050002;  // addi $5,$0,2
      rom[2] = 32'h00251020;  // add  $2,$1,$5
      rom[3] = 32'h00411822;  // sub  $3,$2,$1
      rom[4] = 32'h8C04002C;  // lw   $4,44($0)
      rom[5] = 32'h00843020;  // add  $6,$4,$4
      rom[6] = 32'hAC060028;  // sw   $6,40($0)
      rom[7] = 32'h10650000;  // beq  $3,$5,+0
      rom[8] = 32'h1000FFFF;  // beq  $0,$0,-1
    end
  end

  assign instr       = rom[addr[AW+1:2]];
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
endmodule

module data_memory #(
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd
);
  localparam int AW = $clog2(DMEM_WORDS);

  logic [31:0] memory [0:DMEM_WORDS-1] = '{11: 32'd10, default: 32'd0};
  logic        unused_addr;

  always_ff @(posedge clk) begin
    if (we) memory[addr[AW+1:2]] <= wd;
  end

  assign rd          = memory[addr[AW+1:2]];
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
endmodule

module mips_single_cycle #(
  parameter int    IMEM_WORDS = 64,
  parameter int    DMEM_WORDS = 64,
  parameter string IMEM_INIT  = ""
) (
  input  logic clk,
  input  logic reset
);
  logic [31:0] pc_cur, pc_plus4, pc_next, instr;
  logic [31:0] rs_val, rt_val, simm, mem_addr, mem_rd, wd;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, wa;
  logic        reg_we, mem_we;

  assign op       = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign funct    = instr[5:0];
  assign simm     = {{16{instr[15]}}, instr[15:0]};
  assign pc_plus4 = pc_cur + 32'd4;
  assign mem_addr = rs_val + simm;

  always_comb begin
    reg_we  = 1'b0;
    mem_we  = 1'b0;
    wa      = rd;
    wd      = '0;
    pc_next = pc_plus4;
    case (op)
      6'h00: begin
        reg_we = 1'b1;
        case (funct)
          6'h20:   wd = rs_val + rt_val;
          6'h22:   wd = rs_val - rt_val;
          6'h24:   wd = rs_val & rt_val;
          6'h25:   wd = rs_val | rt_val;
          6'h2A:   wd = {31'd0, $signed(rs_val) < $signed(rt_val)};
          default: reg_we = 1'b0;
        endcase
      end
      // addi reuses the address adder: rs + simm
      6'h08: begin
        reg_we = 1'b1;
        wa     = rt;
        wd     = mem_addr;
      end
      6'h23: begin
        reg_we = 1'b1;
        wa     = rt;
        wd     = mem_rd;
      end
      6'h2B: mem_we = 1'b1;
      6'h04: if (rs_val == rt_val) pc_next = pc_plus4 + {simm[29:0], 2'b00};
      6'h02: pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
      default: ;
    endcase
  end

  pc pc_inst (
    .clk     (clk),
    .reset   (reset),
    .pc_next (pc_next),
    .pc_out  (pc_cur)
  );

  instruction_memory #(.IMEM_WORDS(IMEM_WORDS), .IMEM_INIT(IMEM_INIT)) instruction_memory_inst (
    .addr  (pc_cur),
    .instr (instr)
  );

  register_file register_file_inst (
    .clk   (clk),
    .reset (reset),
    .we    (reg_we),
    .ra1   (rs),
    .ra2   (rt),
    .wa    (wa),
    .wd    (wd),
    .rd1   (rs_val),
    .rd2   (rt_val)
  );

  // a reset edge must not let the in-flight store reach memory
  data_memory #(.DMEM_WORDS(DMEM_WORDS)) data_memory_inst (
    .clk  (clk),
    .we   (mem_we & ~reset),
    .addr (mem_addr),
    .wd   (rt_val),
    .rd   (mem_rd)
  );
endmodule

// File: tb/tb_mips_single_cycle.sv
// Bench for mips_single_cycle: directed tables on the built-in and custom programs, a mid-run
// reset sequence, then random programs checked against an instruction-level interpreter.

module tb_mips_single_cycle;
  localparam int IW = 64;
  localparam int DW = 64;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  mips_single_cycle #(.IMEM_WORDS(IW), .DMEM_WORDS(DW), .IMEM_INIT("")) dut (
    .clk   (clk),
    .reset (reset)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] tb_rom [0:IW-1];
  logic [31:0] m_pc;
  logic [31:0] m_regs [0:31];
  logic [31:0] m_dmem [0:DW-1];

  typedef struct {
    int          test;
    int          edge_no;
    int          kind;     // 0 pc, 1 register, 2 data word
    int          idx;
    logic [31:0] exp;
  } chk_t;
  chk_t tbl[$];

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
    logic [4:0] s = 5'(rs);
    logic [4:0] t = 5'(rt);
    logic [4:0] d = 5'(rd);
    return {6'h00, s, t, d, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
    logic [4:0]  s = 5'(rs);
    logic [4:0]  t = 5'(rt);
    logic [15:0] m = 16'(imm);
    return {op, s, t, m};
  endfunction

  function automatic logic [31:0] enc_j(input int target);
    logic [25:0] t = 26'(target);
    return {6'h02, t};
  endfunction

  function automatic logic [31:0] dut_val(input int kind, input int idx);
    case (kind)
      0:       return dut.pc_inst.pc_out;
      1:       return dut.register_file_inst.regs[idx];
      default: return dut.data_memory_inst.memory[idx];
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic set_reg(input int idx, input logic [31:0] v);
    if (idx != 0) m_regs[idx] = v;
  endtask

  // ISA-level interpreter: one architectural instruction per call
  task automatic model_step(input logic r);
    logic [31:0] ins, a, b, simm, ea, nxt;
    int rs, rt, rd, widx;
    if (r) begin
      m_pc = 0;
      for (int i = 0; i < 32; i++) m_regs[i] = 0;
      return;
    end
    ins  = tb_rom[int'((m_pc / 4) % IW)];
    rs   = int'(ins[25:21]);
    rt   = int'(ins[20:16]);
    rd   = int'(ins[15:11]);
    a    = m_regs[rs];
    b    = m_regs[rt];
    simm = {{16{ins[15]}}, ins[15:0]};
    ea   = a + simm;
    widx = int'((ea / 4) % DW);
    nxt  = m_pc + 4;
    case (ins[31:26])
      6'h00: case (ins[5:0])
        6'h20:   set_reg(rd, a + b);
        6'h22:   set_reg(rd, a - b);
        6'h24:   set_reg(rd, a & b);
        6'h25:   set_reg(rd, a | b);
        6'h2A:   set_reg(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
        default: ;
      endcase
      6'h08: set_reg(rt, ea);
      6'h23: set_reg(rt, m_dmem[widx]);
      6'h2B: m_dmem[widx] = b;
      6'h04: if (a == b) nxt = m_pc + 4 + simm * 4;
      6'h02: nxt = {nxt[31:28], ins[25:0], 2'b00};
      default: ;
    endcase
    m_pc = nxt;
  endtask

  task automatic tick(input logic r);
    reset = r;
    @(posedge clk);
    model_step(r);
    #1;
  endtask

  task automatic load_rom(input logic [31:0] words[$], input bit poke);
    for (int i = 0; i < IW; i++) begin
      tb_rom[i] = (i < words.size()) ? words[i] : 32'h0;
      if (poke) dut.instruction_memory_inst.rom[i] = tb_rom[i];
    end
  endtask

  task automatic compare_model(input string tag, input bit with_mem);
    check({tag, " pc"}, dut_val(0, 0), m_pc);
    for (int i = 0; i < 32; i++) check($sformatf("%s r%0d", tag, i), dut_val(1, i), m_regs[i]);
    if (with_mem)
      for (int i = 0; i < DW; i++) check($sformatf("%s mem%0d", tag, i), dut_val(2, i), m_dmem[i]);
  endtask

  task automatic apply_checks(input int test, input int e);
    foreach (tbl[k])
      if (tbl[k].test == test && tbl[k].edge_no == e)
        check($sformatf("t%0d e%0d k%0d[%0d]", test, e, tbl[k].kind, tbl[k].idx),
              dut_val(tbl[k].kind, tbl[k].idx), tbl[k].exp);
  endtask

  task automatic run_table(input int test, input int n_edges);
    tick(1'b1);
    apply_checks(test, 0);
    for (int e = 1; e <= n_edges; e++) begin
      tick(1'b0);
      apply_checks(test, e);
      compare_model($sformatf("t%0d e%0d model", test, e), 1'b0);
    end
  endtask

  function automatic void add(input int test, input int e, input int kind, input int idx, input logic [31:0] exp);
    chk_t c;
    c.test = test; c.edge_no = e; c.kind = kind; c.idx = idx; c.exp = exp;
    tbl.push_back(c);
  endfunction

  function automatic logic [31:0] rand_instr();
    int k  = int'($urandom_range(0, 11));
    int rs = int'($urandom_range(0, 7));
    int rt = int'($urandom_range(0, 7));
    int rd = int'($urandom_range(0, 7));
    int im = int'($urandom_range(0, 65535));
    case (k)
      0:       return enc_r(rs, rt, rd, 6'h20);
      1:       return enc_r(rs, rt, rd, 6'h22);
      2:       return enc_r(rs, rt, rd, 6'h24);
      3:       return enc_r(rs, rt, rd, 6'h25);
      4:       return enc_r(rs, rt, rd, 6'h2A);
      5:       return enc_i(6'h08, rs, rt, im);
      6:       return enc_i(6'h23, rs, rt, im);
      7:       return enc_i(6'h2B, rs, rt, im);
      8:       return enc_i(6'h04, rs, rt, int'($urandom_range(0, 8)) - 3);
      9:       return enc_j(int'($urandom));
      10:      return enc_r(rs, rt, rd, 6'h21);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] prog[$];

    m_pc = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
    for (int i = 0; i < DW; i++) m_dmem[i] = (i == 11) ? 32'd10 : 32'd0;

    // test 0: built-in program
    add(0, 0, 0, 0, 0);  add(0, 0, 1, 1, 0);  add(0, 0, 1, 5, 0);
    add(0, 3, 1, 1, 3);  add(0, 3, 1, 5, 2);  add(0, 3, 1, 2, 5);  add(0, 3, 0, 0, 12);
    add(0, 4, 1, 3, 2);  add(0, 5, 1, 4, 10); add(0, 5, 2, 11, 10);
    add(0, 7, 2, 10, 20); add(0, 7, 1, 6, 20);
    for (int e = 8; e <= 20; e++) add(0, e, 0, 0, 32);
    // test 1: $0 writes, slt signed, and/or, unsupported encodings, same-register read/write
    add(1, 1, 1, 0, 0);  add(1, 2, 1, 1, 32'hFFFFFFFB); add(1, 3, 1, 2, 1); add(1, 4, 1, 3, 0);
    add(1, 6, 1, 5, 8);  add(1, 7, 1, 6, 13); add(1, 8, 0, 0, 32); add(1, 9, 1, 7, 0);
    add(1, 9, 0, 0, 36); add(1, 10, 1, 1, 32'hFFFFFFF6);
    // test 2: wrap-around arithmetic
    add(2, 1, 1, 1, 32'h00007FFF); add(2, 17, 1, 1, 32'h7FFF0000);
    add(2, 20, 1, 1, 32'h7FFFFFFF); add(2, 21, 1, 7, 32'hFFFFFFFE);
    // test 3: branches, jump, address wrap and ignored low address bits
    add(3, 2, 0, 0, 8);  add(3, 3, 0, 0, 20); add(3, 4, 0, 0, 36); add(3, 5, 2, 3, 1);
    add(3, 6, 2, 63, 1); add(3, 7, 1, 4, 1);  add(3, 7, 1, 2, 0);  add(3, 8, 0, 0, 0);
    add(3, 8, 1, 3, 0);
    // test 4: prefix of the mid-run reset sequence
    add(4, 3, 0, 0, 12); add(4, 3, 1, 1, 5); add(4, 3, 1, 2, 9); add(4, 3, 2, 20, 5);

    prog = '{enc_i(6'h08, 0, 1, 3), enc_i(6'h08, 0, 5, 2), enc_r(1, 5, 2, 6'h20),
             enc_r(2, 1, 3, 6'h22), enc_i(6'h23, 0, 4, 44), enc_r(4, 4, 6, 6'h20),
             enc_i(6'h2B, 0, 6, 40), enc_i(6'h04, 3, 5, 0), enc_i(6'h04, 0, 0, -1)};
    load_rom(prog, 1'b0);
    run_table(0, 20);

    prog = '{enc_i(6'h08, 0, 0, 7), enc_i(6'h08, 0, 1, -5), enc_r(1, 0, 2, 6'h2A),
             enc_r(0, 1, 3, 6'h2A), enc_i(6'h08, 0, 4, 12), enc_r(4, 1, 5, 6'h24),
             enc_r(4, 2, 6, 6'h25), 32'hFC000000, enc_r(1, 1, 7, 6'h21), enc_r(1, 1, 1, 6'h20)};
    load_rom(prog, 1'b1);
    run_table(1, 10);

    prog.delete();
    prog.push_back(enc_i(6'h08, 0, 1, 16'h7FFF));
    for (int i = 0; i < 16; i++) prog.push_back(enc_r(1, 1, 1, 6'h20));
    prog.push_back(enc_i(6'h08, 1, 1, 16'h7FFF));
    prog.push_back(enc_i(6'h08, 1, 1, 16'h7FFF));
    prog.push_back(enc_i(6'h08, 1, 1, 1));
    prog.push_back(enc_r(1, 1, 7, 6'h20));
    load_rom(prog, 1'b1);
    run_table(2, 21);

    prog = '{enc_i(6'h08, 0, 1, 1), enc_i(6'h04, 1, 0, 5), enc_i(6'h04, 1, 1, 2),
             enc_i(6'h08, 0, 2, 99), enc_i(6'h08, 0, 2, 98), enc_j(9),
             enc_i(6'h08, 0, 3, 1), enc_i(6'h08, 0, 3, 1), enc_i(6'h08, 0, 3, 1),
             enc_i(6'h2B, 0, 1, 16'h100E), enc_i(6'h2B, 0, 1, -4), enc_i(6'h23, 0, 4, 16'h00FF),
             enc_i(6'h04, 0, 0, -13)};
    load_rom(prog, 1'b1);
    run_table(3, 8);

    // mid-run reset lands on the edge of a store that must not happen
    prog = '{enc_i(6'h08, 0, 1, 5), enc_i(6'h2B, 0, 1, 80), enc_i(6'h08, 0, 2, 9),
             enc_i(6'h2B, 0, 2, 84)};
    load_rom(prog, 1'b1);
    run_table(4, 3);
    tick(1'b1);
    check("midreset pc", dut_val(0, 0), 32'd0);
    for (int i = 0; i < 32; i++) check($sformatf("midreset r%0d", i), dut_val(1, i), 32'd0);
    check("midreset mem20", dut_val(2, 20), 32'd5);
    check("midreset mem21 sw suppressed", dut_val(2, 21), 32'd0);
    compare_model("midreset model", 1'b1);
    tick(1'b0);
    check("restart pc", dut_val(0, 0), 32'd4);
    check("restart r1", dut_val(1, 1), 32'd5);

    for (int p = 0; p < 12; p++) begin
      prog.delete();
      for (int i = 0; i < IW; i++) prog.push_back(rand_instr());
      load_rom(prog, 1'b1);
      tick(1'b1);
      compare_model($sformatf("rand%0d reset", p), 1'b1);
      for (int c = 0; c < 150; c++) begin
        logic r = ($urandom_range(0, 79) == 0);
        tick(r);
        compare_model($sformatf("rand%0d c%0d", p, c), r);
      end
      compare_model($sformatf("rand%0d end", p), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
